// File: rtl/activation_pipe.sv
// Three-stage fixed-point activation unit (sigmoid, tanh, ReLU, identity) with a
// valid/ready stream interface; the whole pipeline advances or holds as one.
module activation_pipe #(
    parameter int WIDTH = 32,
    parameter int FL    = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y
);

    typedef enum logic [1:0] {
        M_SIG  = 2'd0,
        M_TANH = 2'd1,
        M_RELU = 2'd2,
        M_ID   = 2'd3
    } mode_t;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1) << FL;
    localparam logic [WIDTH-1:0] FOUR = ONE << 2;

    logic adv;

    logic             v1, v2;
    mode_t            mode1, mode2;
    logic [WIDTH-1:0] a1, a2;
    logic             neg1, neg2;
    logic [WIDTH-1:0] u1, sq2;

    logic [WIDTH-1:0] xs;
    logic [WIDTH:0]   mag;
    logic [WIDTH-1:0] m_n, u_n;
    logic             neg_n;
    logic [WIDTH-1:0] sq_n;
    logic [WIDTH-1:0] s_n, sig_n, y_n;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // S1: scale for tanh (saturating), take sign and clamped magnitude
    always_comb begin
        xs = a;
        if (mode_t'(in_mode) == M_TANH) begin
            if (a[WIDTH-1] != a[WIDTH-2])
                xs = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            else
                xs = {a[WIDTH-2:0], 1'b0};
        end
        neg_n = xs[WIDTH-1];
        // one extra bit so the most-negative word has a representable magnitude
        mag   = neg_n ? -{1'b1, xs} : {1'b0, xs};
        m_n   = (mag >= {1'b0, FOUR}) ? FOUR : mag[WIDTH-1:0];
        u_n   = ONE - (m_n >> 2);
    end

    // S2: square in double width, truncate back to Q format
    always_comb begin
        sq_n = WIDTH'(({{WIDTH{1'b0}}, u1} * {{WIDTH{1'b0}}, u1}) >> FL);
    end

    // S3: fold the half-parabola back into sigmoid/tanh, or pass a through
    always_comb begin
        s_n   = ONE - (sq2 >> 1);
        sig_n = neg2 ? (ONE - s_n) : s_n;
        y_n   = a2;
        case (mode2)
            M_SIG:  y_n = sig_n;
            M_TANH: y_n = (sig_n << 1) - ONE;
            M_RELU: y_n = a2[WIDTH-1] ? '0 : a2;
            M_ID:   y_n = a2;
            default: y_n = a2;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            mode1     <= M_SIG;
            mode2     <= M_SIG;
            a1        <= '0;
            a2        <= '0;
            neg1      <= 1'b0;
            neg2      <= 1'b0;
            u1        <= '0;
            sq2       <= '0;
            y         <= '0;
        end else if (adv) begin
            v1        <= in_valid;
            mode1     <= mode_t'(in_mode);
            a1        <= a;
            neg1      <= neg_n;
            u1        <= u_n;

            v2        <= v1;
            mode2     <= mode1;
            a2        <= a1;
            neg2      <= neg1;
            sq2       <= sq_n;

            out_valid <= v2;
            y         <= y_n;
        end
    end

endmodule

// File: tb/tb_activation_pipe.sv
// Randomised and directed bench for activation_pipe against an arithmetic model
// of the activation formulas, with an in-order scoreboard and latency tracking.
module tb_activation_pipe;

    localparam longint ONE_L = 64'd1 << 24;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [31:0] a;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;

    activation_pipe #(.WIDTH(32), .FL(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    int          acc_cyc_q[$];
    int          acc_stall_q[$];
    logic [31:0] got_q[$];
    int          cyc = 0;
    int          stalls = 0;
    int          n_acc = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_y = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // y = f(mode, a) straight from the formula with 64-bit integer arithmetic
    function automatic logic [31:0] model(input logic [1:0] md, input logic [31:0] av);
        longint x, ax, m, u, sq, s, sig;
        if (md == 2'd2) return ($signed(av) < 0) ? 32'd0 : av;
        if (md == 2'd3) return av;
        x = longint'($signed(av));
        if (md == 2'd1) begin
            x = 2 * x;
            if (x > 64'sd2147483647)  x = 64'sd2147483647;
            if (x < -64'sd2147483648) x = -64'sd2147483648;
        end
        ax  = (x < 0) ? -x : x;
        m   = (ax > 4 * ONE_L) ? 4 * ONE_L : ax;
        u   = ONE_L - m / 4;
        sq  = (u * u) / ONE_L;
        s   = ONE_L - sq / 2;
        sig = (x < 0) ? ONE_L - s : s;
        if (md == 2'd0) return 32'(sig);
        return 32'(2 * sig - ONE_L);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, !out_valid || out_ready});
            if (prev_stall) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_y", y, prev_y);
            end
            if (out_valid && exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stale_output actual=valid y=%h required=no output", y);
            end else if (out_valid && out_ready) begin
                check("y", y, exp_q.pop_front());
                check("latency", cyc - acc_cyc_q.pop_front(), 3 + stalls - acc_stall_q.pop_front());
                got_q.push_back(y);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_mode, a));
                acc_cyc_q.push_back(cyc);
                acc_stall_q.push_back(stalls);
                n_acc++;
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = y;
            if (prev_stall) stalls++;
        end
        cyc++;
    end

    task automatic send(input logic [1:0] md, input logic [31:0] av);
        logic acc;
        int   k;
        in_valid = 1'b1;
        in_mode  = md;
        a        = av;
        k        = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            k++;
        end while (!acc && k < 1000);
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=no accept required=accept within 1000 cycles");
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_got(input string name, input logic [31:0] req[]);
        check({name, "_count"}, got_q.size(), req.size());
        for (int i = 0; i < req.size() && i < got_q.size(); i++)
            check(name, got_q[i], req[i]);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] edges[8];
        edges = '{32'h80000000, 32'h7FFFFFFF, 32'h00000000, 32'h04000000,
                  32'hFC000000, 32'h03FFFFFF, 32'hFC000001, 32'hFFFFFFFF};
        case ($urandom % 4)
            0: return $urandom;
            1: return 32'($urandom_range(0, 32'h10000000)) - 32'h08000000;
            2: return edges[$urandom % 8];
            default: return 32'($urandom_range(0, 32'h00100000)) - 32'h00080000;
        endcase
    endfunction

    initial begin
        logic [31:0] r1[], r2[], r3[], r4[];
        int budget;

        rst = 1'b0;
        in_valid = 1'b0;
        in_mode = 2'd0;
        a = '0;
        out_ready = 1'b1;

        // formula anchors for the model itself
        check("model_sig_0",  model(2'd0, 32'h00000000), 32'h00800000);
        check("model_sig_1",  model(2'd0, 32'h01000000), 32'h00B80000);
        check("model_tanh_m1", model(2'd1, 32'hFF000000), 32'hFF400000);
        check("model_tanh_min", model(2'd1, 32'h80000000), 32'hFF000000);

        #12;
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_y", y, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: sigmoid back-to-back
        got_q.delete();
        send(2'd0, 32'hFB000000);
        send(2'd0, 32'hFE000000);
        send(2'd0, 32'h00000000);
        send(2'd0, 32'h01000000);
        send(2'd0, 32'h05000000);
        in_valid = 1'b0;
        drain();
        r1 = '{32'h00000000, 32'h00200000, 32'h00800000, 32'h00B80000, 32'h01000000};
        check_got("t1_sigmoid", r1);

        // 2: tanh
        got_q.delete();
        send(2'd1, 32'h01000000);
        send(2'd1, 32'hFF000000);
        send(2'd1, 32'h00000000);
        send(2'd1, 32'h7FFFFFFF);
        in_valid = 1'b0;
        drain();
        r2 = '{32'h00C00000, 32'hFF400000, 32'h00000000, 32'h01000000};
        check_got("t2_tanh", r2);

        // 3: mixed modes
        got_q.delete();
        send(2'd2, 32'hFD800000);
        send(2'd0, 32'h02000000);
        send(2'd3, 32'hFD800000);
        send(2'd0, 32'hFE000000);
        send(2'd2, 32'h01000000);
        send(2'd3, 32'h7FFFFFFF);
        in_valid = 1'b0;
        drain();
        r3 = '{32'h00000000, 32'h00E00000, 32'hFD800000, 32'h00200000, 32'h01000000, 32'h7FFFFFFF};
        check_got("t3_mixed", r3);

        // 4: back-pressure mid-stream
        got_q.delete();
        fork
            begin
                send(2'd0, 32'h00000000);
                send(2'd1, 32'h01000000);
                send(2'd2, 32'hFD800000);
                send(2'd3, 32'h12345678);
                send(2'd0, 32'hFE000000);
                send(2'd1, 32'hFF000000);
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        r4 = '{32'h00800000, 32'h00C00000, 32'h00000000, 32'h12345678, 32'h00200000, 32'hFF400000};
        check_got("t4_backpressure", r4);

        // 5: asynchronous reset with words in flight
        send(2'd0, 32'h01000000);
        send(2'd1, 32'h01000000);
        send(2'd3, 32'h0000ABCD);
        in_valid = 1'b0;
        check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        #1 rst = 1'b0;
        #1;
        check("async_reset_valid", {31'd0, out_valid}, 32'd0);
        check("async_reset_y", y, 32'd0);
        exp_q.delete();
        acc_cyc_q.delete();
        acc_stall_q.delete();
        prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        got_q.delete();
        send(2'd3, 32'h0BADF00D);
        in_valid = 1'b0;
        drain();
        check("t5_after_reset_count", got_q.size(), 1);
        if (got_q.size() > 0) check("t5_after_reset_y", got_q[0], 32'h0BADF00D);

        // 6: random traffic, all modes
        budget = 0;
        n_acc = 0;
        while (n_acc < 10000 && budget < 60000) begin
            in_valid  = ($urandom % 10) < 7;
            in_mode   = 2'($urandom % 4);
            a         = rand_word();
            out_ready = ($urandom % 4) != 0;
            @(posedge clk);
            #1;
            budget++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (n_acc < 10000) begin
            total++;
            bad++;
            $display("FAIL random_budget actual=%0d accepted required=10000", n_acc);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
